seq_calculator: RTL and testbench

Parametrised, multi-cycle successor to the 3-mode combinational calculator. It adds a fourth mode (divide), a start/busy/done handshake, registered outputs and an error flag. Add and subtract complete in one cycle. Multiply uses shift-add and divide uses restoring division, each iterating one bit per clock. The block sits between operand registers/switch inputs and the display/result path.

---
 rtl/seq_calculator_if.sv | 26 ++
 rtl/seq_calculator.sv | 160 ++++++++++++++++
 tb/tb_seq_calculator.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_calculator_if.sv
// rtl/seq_calculator_if.sv - request/response bundle for seq_calculator
interface seq_calculator_if #(
  parameter int WIDTH = 5
);
  localparam int RES_W = 2 * WIDTH;

  logic             i_Start;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic [1:0]       i_Calc;
  logic             o_Busy;
  logic             o_Done;
  logic [RES_W-1:0] o_Result;
  logic             o_Neg;
  logic             o_Err;

  modport master (
    output i_Start, i_A, i_B, i_Calc,
    input  o_Busy, o_Done, o_Result, o_Neg, o_Err
  );

  modport slave (
    input  i_Start, i_A, i_B, i_Calc,
    output o_Busy, o_Done, o_Result, o_Neg, o_Err
  );
endinterface

// File: rtl/seq_calculator.sv
// rtl/seq_calculator.sv - multi-cycle add/sub/mul/div calculator; CALC_DIV_EN builds the divider
module seq_calculator #(
  parameter int WIDTH = 5
) (
  input  logic           i_Clk,
  input  logic           i_Rst_n,
  seq_calculator_if.slave bus
);
  localparam int RES_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       calc_q;
  logic [CNT_W-1:0] cnt;
  logic [RES_W-1:0] acc;
  logic [RES_W-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [RES_W-1:0] mul_acc_next;
  logic             last_iter;

  assign mul_acc_next = acc + (mplr[0] ? mcand : '0);
  assign last_iter    = (cnt == CNT_W'(1));

`ifdef CALC_DIV_EN
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_fit;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quot_next;

  // A borrow out of the trial subtraction means the divisor did not fit.
  assign div_shift     = {rem, quot[WIDTH-1]};
  assign div_diff      = div_shift - {1'b0, divisor};
  assign div_fit       = ~div_diff[WIDTH];
  assign div_rem_next  = div_fit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quot_next = {quot[WIDTH-2:0], div_fit};
`endif

  assign bus.o_Busy = (state != IDLE);
  assign bus.o_Done = (state == DONE);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.i_Start) begin
          if (bus.i_Calc == 2'd2) state_next = RUN;
`ifdef CALC_DIV_EN
          else if (bus.i_Calc == 2'd3 && bus.i_B != '0) state_next = RUN;
`endif
          else state_next = DONE;
        end
      end
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      calc_q       <= '0;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplr         <= '0;
      bus.o_Result <= '0;
      bus.o_Neg    <= 1'b0;
      bus.o_Err    <= 1'b0;
`ifdef CALC_DIV_EN
      rem          <= '0;
      quot         <= '0;
      divisor      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_Start) begin
            calc_q <= bus.i_Calc;
            cnt    <= CNT_W'(WIDTH);
            acc    <= '0;
            mcand  <= RES_W'(bus.i_A);
            mplr   <= bus.i_B;
`ifdef CALC_DIV_EN
            rem     <= '0;
            quot    <= bus.i_A;
            divisor <= bus.i_B;
`endif
            // Single-cycle modes and the error cases resolve on the capture edge.
            case (bus.i_Calc)
              2'd0: begin
                bus.o_Result <= RES_W'(bus.i_A) + RES_W'(bus.i_B);
                bus.o_Neg    <= 1'b0;
                bus.o_Err    <= 1'b0;
              end
              2'd1: begin
                if (bus.i_A < bus.i_B) begin
                  bus.o_Result <= RES_W'(bus.i_B - bus.i_A);
                  bus.o_Neg    <= 1'b1;
                end else begin
                  bus.o_Result <= RES_W'(bus.i_A - bus.i_B);
                  bus.o_Neg    <= 1'b0;
                end
                bus.o_Err <= 1'b0;
              end
              2'd2: ;
              default: begin
`ifdef CALC_DIV_EN
                if (bus.i_B == '0) begin
                  bus.o_Result <= '0;
                  bus.o_Neg    <= 1'b0;
                  bus.o_Err    <= 1'b1;
                end
`else
                bus.o_Result <= '0;
                bus.o_Neg    <= 1'b0;
                bus.o_Err    <= 1'b1;
`endif
              end
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (calc_q == 2'd2) begin
            acc   <= mul_acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
          end
`ifdef CALC_DIV_EN
          else begin
            rem  <= div_rem_next;
            quot <= div_quot_next;
          end
`endif
          if (last_iter) begin
`ifdef CALC_DIV_EN
            bus.o_Result <= (calc_q == 2'd2) ? mul_acc_next : {div_rem_next, div_quot_next};
`else
            bus.o_Result <= (calc_q == 2'd2) ? mul_acc_next : '0;
`endif
            bus.o_Neg <= 1'b0;
            bus.o_Err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_calculator.sv
// tb/tb_seq_calculator.sv - directed and random checks of seq_calculator against an arithmetic model
module tb_seq_calculator;
  localparam int WIDTH = 5;
  localparam int RES_W = 2 * WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_asserts = 0;
  int   n_fail = 0;

  seq_calculator_if #(.WIDTH(WIDTH)) bus ();

  seq_calculator #(.WIDTH(WIDTH)) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected outcome straight from the arithmetic definition of each mode.
  function automatic void model(input int a, input int b, input int c,
                                output int res, output int neg, output int err, output int lat);
    res = 0; neg = 0; err = 0; lat = 1;
    case (c)
      0: res = a + b;
      1: begin res = (a >= b) ? a - b : b - a; neg = (a < b) ? 1 : 0; end
      2: begin res = a * b; lat = WIDTH + 1; end
      default: begin
`ifdef CALC_DIV_EN
        if (b == 0) err = 1;
        else begin res = ((a % b) << WIDTH) + (a / b); lat = WIDTH + 1; end
`else
        err = 1;
`endif
      end
    endcase
  endfunction

  task automatic do_op(input int a, input int b, input int c, input bit stray, input string tag);
    int er, en, ee, el, cyc, busy_cnt;
    model(a, b, c, er, en, ee, el);
    @(negedge clk);
    bus.i_A = WIDTH'(a); bus.i_B = WIDTH'(b); bus.i_Calc = 2'(c); bus.i_Start = 1'b1;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    cyc = 1; busy_cnt = 0;
    forever begin
      if (bus.o_Busy) busy_cnt++;
      if (bus.o_Done || cyc >= 40) break;
      bus.i_A = WIDTH'($urandom); bus.i_B = WIDTH'($urandom); bus.i_Calc = 2'($urandom);
      bus.i_Start = (stray && cyc == 2) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_Start = 1'b0;
    check({tag, " latency"}, cyc, el);
    check({tag, " busy_cycles"}, busy_cnt, el);
    check({tag, " result"}, 32'(bus.o_Result), er);
    check({tag, " neg"}, 32'(bus.o_Neg), en);
    check({tag, " err"}, 32'(bus.o_Err), ee);
    @(posedge clk); #1;
    check({tag, " done_after"}, 32'(bus.o_Done), 0);
    check({tag, " busy_after"}, 32'(bus.o_Busy), 0);
    check({tag, " result_held"}, 32'(bus.o_Result), er);
  endtask

  initial begin
    int a, b, c, dones;
    bus.i_Start = 1'b0; bus.i_A = '0; bus.i_B = '0; bus.i_Calc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(bus.o_Busy), 0);
    check("reset done", 32'(bus.o_Done), 0);
    check("reset result", 32'(bus.o_Result), 0);
    check("reset neg", 32'(bus.o_Neg), 0);
    check("reset err", 32'(bus.o_Err), 0);
    @(negedge clk); rst_n = 1'b1;

    do_op(31, 31, 0, 1'b0, "add 31+31");
    do_op(3, 10, 1, 1'b0, "sub 3-10");
    do_op(12, 12, 1, 1'b0, "sub 12-12");
    do_op(31, 31, 2, 1'b0, "mul 31*31");
    do_op(29, 4, 3, 1'b0, "div 29/4");
    do_op(9, 0, 3, 1'b0, "div 9/0");
    do_op(31, 31, 2, 1'b1, "mul with stray start");
    do_op(0, 31, 2, 1'b0, "mul 0*31");
    do_op(31, 1, 3, 1'b1, "div 31/1");

    // Start held high: back-to-back adds every two cycles.
    @(negedge clk);
    bus.i_A = 5'd5; bus.i_B = 5'd6; bus.i_Calc = 2'd0; bus.i_Start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("held start done[%0d]", k), 32'(bus.o_Done), (k % 2 == 0) ? 1 : 0);
    end
    bus.i_Start = 1'b0;
    check("held start result", 32'(bus.o_Result), 11);
    @(posedge clk); #1;

    // Reset in the middle of a multiply.
    @(negedge clk);
    bus.i_A = 5'd7; bus.i_B = 5'd9; bus.i_Calc = 2'd2; bus.i_Start = 1'b1;
    @(posedge clk); #1;
    bus.i_Start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrun reset busy", 32'(bus.o_Busy), 0);
    check("midrun reset done", 32'(bus.o_Done), 0);
    check("midrun reset result", 32'(bus.o_Result), 0);
    check("midrun reset neg", 32'(bus.o_Neg), 0);
    check("midrun reset err", 32'(bus.o_Err), 0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.o_Done) dones++;
    end
    check("midrun reset no done", dones, 0);
    do_op(1, 1, 0, 1'b0, "add 1+1 after reset");

    for (int k = 0; k < 30; k++) begin
      c = $urandom_range(0, 3);
      a = $urandom_range(0, 31);
      b = (c == 3 && $urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 31);
      do_op(a, b, c, 1'($urandom_range(0, 1)), $sformatf("rand%0d op%0d %0d,%0d", k, c, a, b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
